// File: rtl/video_read_arbiter.sv
// Two-master AXI4 read arbiter: grants AR bursts by priority into one registered
// request slot and steers in-order R beats back using a FIFO of granted master IDs.
module video_read_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter bit STRICT_M0   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_ar_valid,
  output logic        m0_ar_ready,
  input  logic [31:0] m0_ar_payload_addr,
  input  logic [7:0]  m0_ar_payload_len,
  input  logic [1:0]  m0_ar_payload_burst,
  input  logic        m1_ar_valid,
  output logic        m1_ar_ready,
  input  logic [31:0] m1_ar_payload_addr,
  input  logic [7:0]  m1_ar_payload_len,
  input  logic [1:0]  m1_ar_payload_burst,
  output logic        m0_r_valid,
  input  logic        m0_r_ready,
  output logic [31:0] m0_r_payload_data,
  output logic        m0_r_payload_last,
  output logic        m1_r_valid,
  input  logic        m1_r_ready,
  output logic [31:0] m1_r_payload_data,
  output logic        m1_r_payload_last,
  output logic        s_ar_valid,
  input  logic        s_ar_ready,
  output logic [31:0] s_ar_payload_addr,
  output logic [7:0]  s_ar_payload_len,
  output logic [1:0]  s_ar_payload_burst,
  input  logic        s_r_valid,
  output logic        s_r_ready,
  input  logic [31:0] s_r_payload_data,
  input  logic        s_r_payload_last
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTSTANDING);

  logic          r_s_ar_valid;
  logic [31:0]   r_ar_addr;
  logic [7:0]    r_ar_len;
  logic [1:0]    r_ar_burst;
  logic          r_last_grant;
  logic          r_order [OUTSTANDING];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;

  logic w_slot_free;
  logic w_grant;
  logic w_win_m1;
  logic w_empty;
  logic w_head;
  logic w_pop;

  // Arbitration: a grant needs a free slot and room to remember who owns the burst
  always_comb begin
    w_slot_free = ~r_s_ar_valid | s_ar_ready;
    if (STRICT_M0 || !(m0_ar_valid && m1_ar_valid)) begin
      w_win_m1 = ~m0_ar_valid;
    end else begin
      w_win_m1 = ~r_last_grant;
    end
    w_grant = ~reset & w_slot_free & (r_count < FULL_CNT) & (m0_ar_valid | m1_ar_valid);
  end

  assign m0_ar_ready = w_grant & ~w_win_m1;
  assign m1_ar_ready = w_grant & w_win_m1;

  assign s_ar_valid         = r_s_ar_valid;
  assign s_ar_payload_addr  = r_ar_addr;
  assign s_ar_payload_len   = r_ar_len;
  assign s_ar_payload_burst = r_ar_burst;

  // R steering follows the oldest outstanding grant; stray beats stall when empty
  assign w_empty = (r_count == '0);
  assign w_head  = r_order[r_rd_ptr];

  assign m0_r_valid        = ~w_empty & ~w_head & s_r_valid;
  assign m1_r_valid        = ~w_empty &  w_head & s_r_valid;
  assign s_r_ready         = ~w_empty & (w_head ? m1_r_ready : m0_r_ready);
  assign m0_r_payload_data = s_r_payload_data;
  assign m1_r_payload_data = s_r_payload_data;
  assign m0_r_payload_last = s_r_payload_last;
  assign m1_r_payload_last = s_r_payload_last;
  assign w_pop             = s_r_valid & s_r_ready & s_r_payload_last;

  // AR request slot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ar_valid <= 1'b0;
      r_ar_addr    <= '0;
      r_ar_len     <= '0;
      r_ar_burst   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_s_ar_valid <= 1'b1;
      r_ar_addr    <= w_win_m1 ? m1_ar_payload_addr  : m0_ar_payload_addr;
      r_ar_len     <= w_win_m1 ? m1_ar_payload_len   : m0_ar_payload_len;
      r_ar_burst   <= w_win_m1 ? m1_ar_payload_burst : m0_ar_payload_burst;
      r_last_grant <= w_win_m1;
    end else if (s_ar_ready) begin
      r_s_ar_valid <= 1'b0;
    end
  end

  // Order FIFO storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_order[r_wr_ptr] <= w_win_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/video_read_arbiter.md
# video_read_arbiter

Two-master AXI4 read-channel arbiter that merges the video controller's line fetches (master 0) with a second read master (master 1, e.g. CPU-side DMA or blitter) onto the single memory read port. It sits directly upstream of the video controller's `axi_ar_*` / `axi_r_*` interface. It grants bursts by priority, forwards one registered AR request at a time, and routes in-order R beats back to the issuing master using an order FIFO of master IDs.

## Interface
- `OUTSTANDING`, 4: max accepted-but-not-completed bursts; power of two, 2..16.
- `STRICT_M0`, 1: 1 = master 0 always wins contention; 0 = alternate on contention (round robin).
- `clk`  in  1  system clock (single clock domain).
- `reset`  in  1  synchronous, active-high reset.
- `m0_ar_valid`, `m1_ar_valid`  in  1  each  read request valid.
- `m0_ar_ready`, `m1_ar_ready`  out  1  each  request accepted this cycle.
- `m0_ar_payload_addr`, `m1_ar_payload_addr`  in  32  each  byte address.
- `m0_ar_payload_len`, `m1_ar_payload_len`  in  8  each  beats minus 1.
- `m0_ar_payload_burst`, `m1_ar_payload_burst`  in  2  each  burst type, forwarded unchanged.
- `m0_r_valid`, `m1_r_valid`  out  1  each  read beat valid.
- `m0_r_ready`, `m1_r_ready`  in  1  each  read beat ready. Master 0 ties this high.
- `m0_r_payload_data`, `m1_r_payload_data`  out  32  each  read data.
- `m0_r_payload_last`, `m1_r_payload_last`  out  1  each  last beat of burst.
- `s_ar_valid`  out  1  registered request to memory.
- `s_ar_ready`  in  1  memory accepts request.
- `s_ar_payload_addr`  out  32  registered address.
- `s_ar_payload_len`  out  8  registered length.
- `s_ar_payload_burst`  out  2  registered burst type.
- `s_r_valid`  in  1  memory beat valid.
- `s_r_ready`  out  1  beat accepted.
- `s_r_payload_data`  in  32  beat data.
- `s_r_payload_last`  in  1  last beat of burst.

## Operation
- **Slot free:** the AR slot is free when `~s_ar_valid | s_ar_ready`.
- **Grant condition:** a grant can occur when the slot is free, the order FIFO is not full (`count < OUTSTANDING`), and at least one `mX_ar_valid` is high.
- **Winner selection:**
  - `STRICT_M0=1`: m0 wins if valid, else m1.
  - `STRICT_M0=0`: if both are valid, the winner is the master not granted last time (`last_grant` register, reset to 1 so m0 wins first). A single requester always wins.
- **On grant:**
  - `mX_ar_ready` = 1 for the winner only, combinationally in the grant cycle.
  - The payload is latched into `s_ar_*`, and `s_ar_valid` goes to 1 at the next edge.
  - The winner ID is pushed into the order FIFO.
  - `last_grant` is updated.
- **Slot emptying:** if the slot is freed by `s_ar_ready` and there is no new grant, `s_ar_valid` goes to 0 at the next edge.
- **Back-to-back:** handshake and new grant in the same cycle are allowed; `s_ar_valid` stays 1 with the new payload.
- **R routing** is combinational from the FIFO head `h`, valid only when the FIFO is non-empty:
  - `mh_r_valid = s_r_valid`.
  - `s_r_ready = mh_r_ready`.
  - data and last are broadcast to both masters.
  - Non-selected `mX_r_valid` = 0.
- **Empty FIFO:** `s_r_ready` = 0 and both `mX_r_valid` = 0 (stray beats stall).
- **Pop:** on `s_r_valid & s_r_ready & s_r_payload_last`.
- **Same-cycle push and pop:** count is unchanged, and the pushed entry is written behind the popped one. This remains legal when `count == OUTSTANDING`, but a grant still requires `count < OUTSTANDING` pre-pop, so no push occurs at full.
- **FIFO implementation:** registers with `log2(OUTSTANDING)`-bit read/write pointers that wrap naturally, plus a `log2(OUTSTANDING)+1`-bit count.
- **Reset values:**
  - `s_ar_valid`=0, `m0_ar_ready`=`m1_ar_ready`=0, all `mX_r_valid`=0, `s_r_ready`=0.
  - FIFO empty; pointers and count 0.
  - `last_grant`=1.
  - `s_ar_payload_*` = 0.
- **Reset mid-burst:** all in-flight ordering is discarded. The memory port shares `reset` and must drop its own bursts; beats arriving after reset are not routed (they stall, since the FIFO is empty).

## Timing
- **AR latency:** `mX_ar_valid` high with slot free in cycle N → `mX_ar_ready`=1 in cycle N → `s_ar_valid`=1 in cycle N+1.
- **Throughput:** one grant per cycle when `s_ar_ready` is held high.
- **R path:** zero-latency combinational pass-through; no beat buffering.
- **Head advance:** the FIFO head changes at the edge after the last beat handshake, so the first beat of the next burst can route in cycle after last, or the same cycle if already valid.
- **Master obligation:** masters must hold payload stable while `ar_valid`=1 and `ar_ready`=0.

## Test plan
- **Single m0 burst:** m0 request addr=0x0010_0000, len=63; `s_ar_ready`=1 → `m0_ar_ready` in cycle 0, `s_ar_valid` in cycle 1 with the same payload. 64 beats route to m0, `m1_r_valid` stays 0, FIFO returns to empty.
- **Contention, STRICT_M0=1:** both request every cycle for 6 grants → 6 m0 grants, m1 never granted. With `STRICT_M0=0`: grant order m0,m1,m0,m1,m0,m1.
- **Full FIFO:** `s_ar_ready`=1, no R beats, OUTSTANDING=4, m1 requests continuously → exactly 4 grants, then `m1_ar_ready`=0. One last beat → exactly one further grant.
- **Interleaved ordering:** grants m1(len=3), m0(len=1), m1(len=0); memory returns 4+2+1 beats in order with `m1_r_ready` toggling → beats delivered to m1,m1,m1,m1,m0,m0,m1. Stalls only while the head is m1 with `m1_r_ready`=0.
- **Slave stall:** `s_ar_ready`=0 for 5 cycles while m0 requests → `m0_ar_ready` pulses only once, and payload holds. A second grant occurs in the cycle `s_ar_ready` returns to 1 (back-to-back).
- **Reset mid-burst:** assert `reset` at beat 10 of a 64-beat burst → next cycle all valids/readies are 0 and count is 0. A new m0 request after reset is granted normally.
